// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_if
// Purpose  : Bundles the pipeline-side request/response signals and the
//            memory-side bus signals of the memory access controller.
// Ports    : (interface, no ports)
//            pipeline side : req_valid, st_sel, ld_sel, addr, wdata,
//                            stall, rdata, rdata_valid, adel, ades, buserr
//            memory side   : mem_req, mem_we, mem_addr, mem_byteen,
//                            mem_wdata, mem_ack, mem_rdata
// Modports : master - the controller (drives the memory bus and the
//                     pipeline responses)
//            slave  - the environment (drives requests, ack and read data)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;
  // Pipeline request
  logic        req_valid;
  logic [1:0]  st_sel;
  logic [2:0]  ld_sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  // Pipeline response
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        adel;
  logic        ades;
  logic        buserr;
  // Memory bus
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, st_sel, ld_sel, addr, wdata, mem_ack, mem_rdata,
    output stall, rdata, rdata_valid, adel, ades, buserr,
    output mem_req, mem_we, mem_addr, mem_byteen, mem_wdata
  );

  modport slave (
    output req_valid, st_sel, ld_sel, addr, wdata, mem_ack, mem_rdata,
    input  stall, rdata, rdata_valid, adel, ades, buserr,
    input  mem_req, mem_we, mem_addr, mem_byteen, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : M-stage load/store controller. Checks alignment, stalls the
//            pipeline while a word-aligned memory transaction is in flight,
//            generates byte enables / replicated store data, bounds the wait
//            for mem_ack and sign-/zero-extends load data.
// Params   : MAX_WAIT - BUSY cycles without mem_ack before a bus error
//                       (1..255)
// Ports    : clk   - clock, all state on rising edge
//            rst_n - asynchronous active-low reset
//            bus   - mem_access_ctrl_if.master (pipeline + memory signals)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mem_access_ctrl_if.master         bus
);

  localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

  // st_sel encodings
  localparam logic [1:0] c_st_sw   = 2'b00;
  localparam logic [1:0] c_st_sh   = 2'b01;
  localparam logic [1:0] c_st_none = 2'b11;
  // ld_sel encodings
  localparam logic [2:0] c_ld_none = 3'd0;
  localparam logic [2:0] c_ld_lw   = 3'd1;
  localparam logic [2:0] c_ld_lh   = 3'd2;
  localparam logic [2:0] c_ld_lhu  = 3'd3;
  localparam logic [2:0] c_ld_lb   = 3'd4;
  localparam logic [2:0] c_ld_lbu  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q,    state_d;
  logic [7:0]  cnt_q,      cnt_d;
  logic        is_store_q, is_store_d;
  logic [1:0]  st_sel_q,   st_sel_d;
  logic [2:0]  ld_sel_q,   ld_sel_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        buserr_q,   buserr_d;

  // --------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // --------------------------------------------------------------------------
  logic w_st_op;
  logic w_ld_op;
  logic w_st_mis;
  logic w_ld_mis;

  always_comb begin
    // A store takes priority; a simultaneous load is dropped entirely.
    w_st_op  = bus.req_valid && (bus.st_sel != c_st_none);
    w_ld_op  = bus.req_valid && !w_st_op &&
               (bus.ld_sel != c_ld_none) && (bus.ld_sel <= c_ld_lbu);

    w_st_mis = ((bus.st_sel == c_st_sw) && (bus.addr[1:0] != 2'b00)) ||
               ((bus.st_sel == c_st_sh) && bus.addr[0]);
    w_ld_mis = ((bus.ld_sel == c_ld_lw) && (bus.addr[1:0] != 2'b00)) ||
               (((bus.ld_sel == c_ld_lh) || (bus.ld_sel == c_ld_lhu)) &&
                bus.addr[0]);
  end

  // --------------------------------------------------------------------------
  // Byte-lane steering for the captured op
  // --------------------------------------------------------------------------
  logic [3:0]  w_byteen;
  logic [31:0] w_wdata;

  always_comb begin
    w_byteen = 4'b1111;
    w_wdata  = 32'd0;
    if (is_store_q) begin
      case (st_sel_q)
        c_st_sw: begin
          w_byteen = 4'b1111;
          w_wdata  = wdata_q;
        end
        c_st_sh: begin
          w_byteen = addr_q[1] ? 4'b1100 : 4'b0011;
          w_wdata  = {2{wdata_q[15:0]}};
        end
        default: begin
          w_byteen = 4'b0001 << addr_q[1:0];
          w_wdata  = {4{wdata_q[7:0]}};
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Load data extraction and extension
  // --------------------------------------------------------------------------
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_ext;

  always_comb begin
    w_half = addr_q[1] ? mem_data_q[31:16] : mem_data_q[15:0];
    case (addr_q[1:0])
      2'd0:    w_byte = mem_data_q[7:0];
      2'd1:    w_byte = mem_data_q[15:8];
      2'd2:    w_byte = mem_data_q[23:16];
      default: w_byte = mem_data_q[31:24];
    endcase

    case (ld_sel_q)
      c_ld_lw:  w_ext = mem_data_q;
      c_ld_lh:  w_ext = {{16{w_half[15]}}, w_half};
      c_ld_lhu: w_ext = {16'd0, w_half};
      c_ld_lb:  w_ext = {{24{w_byte[7]}}, w_byte};
      c_ld_lbu: w_ext = {24'd0, w_byte};
      default:  w_ext = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    st_sel_d    = st_sel_q;
    ld_sel_d    = ld_sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_data_d  = mem_data_q;
    buserr_d    = buserr_q;

    bus.stall       = 1'b0;
    bus.adel        = 1'b0;
    bus.ades        = 1'b0;
    bus.buserr      = 1'b0;
    bus.rdata       = 32'd0;
    bus.rdata_valid = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = 32'd0;
    bus.mem_byteen  = 4'b0000;
    bus.mem_wdata   = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (w_st_op || w_ld_op) begin
          if (w_st_op && w_st_mis) begin
            bus.ades = 1'b1;
          end else if (w_ld_op && w_ld_mis) begin
            bus.adel = 1'b1;
          end else begin
            bus.stall  = 1'b1;
            state_d    = ST_BUSY;
            cnt_d      = 8'd0;
            is_store_d = w_st_op;
            st_sel_d   = bus.st_sel;
            ld_sel_d   = w_st_op ? c_ld_none : bus.ld_sel;
            addr_d     = bus.addr;
            wdata_d    = bus.wdata;
            mem_data_d = 32'd0;
            buserr_d   = 1'b0;
          end
        end
      end

      ST_BUSY: begin
        bus.stall      = 1'b1;
        bus.mem_req    = 1'b1;
        bus.mem_we     = is_store_q;
        bus.mem_addr   = {addr_q[31:2], 2'b00};
        bus.mem_byteen = w_byteen;
        bus.mem_wdata  = w_wdata;
        if (bus.mem_ack) begin
          mem_data_d = bus.mem_rdata;
          state_d    = ST_DONE;
        end else if ((cnt_q + 8'd1) == c_max_wait) begin
          // MAX_WAIT BUSY cycles have now passed without an ack.
          buserr_d   = 1'b1;
          mem_data_d = 32'd0;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        bus.buserr      = buserr_q;
        bus.rdata_valid = !is_store_q;
        bus.rdata       = (is_store_q || buserr_q) ? 32'd0 : w_ext;
        state_d         = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      is_store_q <= 1'b0;
      st_sel_q   <= c_st_none;
      ld_sel_q   <= c_ld_none;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      mem_data_q <= 32'd0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      st_sel_q   <= st_sel_d;
      ld_sel_q   <= ld_sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_data_q <= mem_data_d;
      buserr_q   <= buserr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed self-checking bench for mem_access_ctrl (MAX_WAIT=4).
//            Inputs change 1 time unit after a rising edge; outputs are
//            sampled in the same window, well away from the next edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .MAX_WAIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.st_sel    = 2'b11;
    bus.ld_sel    = 3'd0;
    bus.addr      = 32'd0;
    bus.wdata     = 32'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
    total++; if (bus.mem_byteen !== 4'b0000) begin bad++; $display("FAIL rst_byteen got=%b exp=0000", bus.mem_byteen); end
    total++; if (bus.rdata_valid !== 1'b0) begin bad++; $display("FAIL rst_rdata_valid got=%b exp=0", bus.rdata_valid); end
    total++; if (bus.buserr !== 1'b0) begin bad++; $display("FAIL rst_buserr got=%b exp=0", bus.buserr); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------
  // Aligned store; mem_ack raised on BUSY cycle ack_cyc (cycle 0 = request).
  task automatic test_store(input string nm, input logic [1:0] st,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input int ack_cyc);
    bus.req_valid = 1'b1;
    bus.st_sel    = st;
    bus.ld_sel    = 3'd0;
    bus.addr      = a;
    bus.wdata     = wd;
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL %s_c0_stall got=%b exp=1", nm, bus.stall); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL %s_c0_mem_req got=%b exp=0", nm, bus.mem_req); end
    tick();
    idle_inputs();
    for (int c = 1; c <= ack_cyc; c++) begin
      if (c == ack_cyc) bus.mem_ack = 1'b1;
      #1;
      total++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.stall !== 1'b1)
        begin bad++; $display("FAIL %s_c%0d_req_we_stall got=%b%b%b exp=111", nm, c, bus.mem_req, bus.mem_we, bus.stall); end
      total++; if (bus.mem_addr !== exp_addr) begin bad++; $display("FAIL %s_c%0d_mem_addr got=%h exp=%h", nm, c, bus.mem_addr, exp_addr); end
      total++; if (bus.mem_byteen !== exp_be) begin bad++; $display("FAIL %s_c%0d_byteen got=%b exp=%b", nm, c, bus.mem_byteen, exp_be); end
      total++; if (bus.mem_wdata !== exp_wd) begin bad++; $display("FAIL %s_c%0d_mem_wdata got=%h exp=%h", nm, c, bus.mem_wdata, exp_wd); end
      tick();
    end
    bus.mem_ack = 1'b0;
    #1;
    total++; if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL %s_done_stall_req got=%b%b exp=00", nm, bus.stall, bus.mem_req); end
    total++; if (bus.rdata_valid !== 1'b0 || bus.buserr !== 1'b0) begin bad++; $display("FAIL %s_done_rv_be got=%b%b exp=00", nm, bus.rdata_valid, bus.buserr); end
    total++; if (bus.rdata !== 32'd0) begin bad++; $display("FAIL %s_done_rdata got=%h exp=0", nm, bus.rdata); end
    tick();
  endtask

  // ---------------------------------------------------------------------
  // Aligned load with immediate ack (BUSY cycle 1).
  task automatic test_load(input string nm, input logic [2:0] ld,
                           input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] exp_rd);
    bus.req_valid = 1'b1;
    bus.ld_sel    = ld;
    bus.addr      = a;
    #1;
    total++; if (bus.stall !== 1'b1 || bus.adel !== 1'b0) begin bad++; $display("FAIL %s_c0_stall_adel got=%b%b exp=10", nm, bus.stall, bus.adel); end
    tick();
    idle_inputs();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    #1;
    total++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_byteen !== 4'b1111)
      begin bad++; $display("FAIL %s_c1_req_we_be got=%b%b%b exp=101111", nm, bus.mem_req, bus.mem_we, bus.mem_byteen); end
    total++; if (bus.rdata_valid !== 1'b0) begin bad++; $display("FAIL %s_c1_rdata_valid got=%b exp=0", nm, bus.rdata_valid); end
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hFFFF_FFFF;
    #1;
    total++; if (bus.rdata !== exp_rd) begin bad++; $display("FAIL %s_rdata got=%h exp=%h", nm, bus.rdata, exp_rd); end
    total++; if (bus.rdata_valid !== 1'b1 || bus.stall !== 1'b0) begin bad++; $display("FAIL %s_done_rv_stall got=%b%b exp=10", nm, bus.rdata_valid, bus.stall); end
    tick();
    total++; if (bus.rdata_valid !== 1'b0) begin bad++; $display("FAIL %s_after_rv got=%b exp=0", nm, bus.rdata_valid); end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_misaligned();
    bus.req_valid = 1'b1;
    bus.ld_sel    = 3'd1;
    bus.addr      = 32'h0000_0001;
    #1;
    total++; if (bus.adel !== 1'b1 || bus.ades !== 1'b0) begin bad++; $display("FAIL mis_lw_adel_ades got=%b%b exp=10", bus.adel, bus.ades); end
    total++; if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL mis_lw_stall_req got=%b%b exp=00", bus.stall, bus.mem_req); end
    tick();
    idle_inputs();
    #1;
    total++; if (bus.mem_req !== 1'b0 || bus.adel !== 1'b0) begin bad++; $display("FAIL mis_lw_next_req_adel got=%b%b exp=00", bus.mem_req, bus.adel); end
    tick();
    bus.req_valid = 1'b1;
    bus.st_sel    = 2'b01;
    bus.addr      = 32'h0000_0003;
    #1;
    total++; if (bus.ades !== 1'b1 || bus.adel !== 1'b0 || bus.stall !== 1'b0)
      begin bad++; $display("FAIL mis_sh_ades_adel_stall got=%b%b%b exp=100", bus.ades, bus.adel, bus.stall); end
    tick();
    idle_inputs();
    #1;
    total++; if (bus.mem_req !== 1'b0 || bus.ades !== 1'b0) begin bad++; $display("FAIL mis_sh_next_req_ades got=%b%b exp=00", bus.mem_req, bus.ades); end
    tick();
  endtask

  // ---------------------------------------------------------------------
  // lw with MAX_WAIT=4. ack_cyc=0 means never acknowledge.
  task automatic test_timeout(input string nm, input int ack_cyc);
    logic exp_be;
    exp_be = (ack_cyc == 0);
    bus.req_valid = 1'b1;
    bus.ld_sel    = 3'd1;
    bus.addr      = 32'h0000_0040;
    tick();
    idle_inputs();
    for (int c = 1; c <= 4; c++) begin
      if (c == ack_cyc) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
      end
      #1;
      total++; if (bus.mem_req !== 1'b1 || bus.buserr !== 1'b0) begin bad++; $display("FAIL %s_c%0d_req_buserr got=%b%b exp=10", nm, c, bus.mem_req, bus.buserr); end
      tick();
    end
    bus.mem_ack = 1'b0;
    #1;
    total++; if (bus.buserr !== exp_be) begin bad++; $display("FAIL %s_buserr got=%b exp=%b", nm, bus.buserr, exp_be); end
    total++; if (bus.rdata !== (exp_be ? 32'd0 : 32'h1234_5678)) begin bad++; $display("FAIL %s_rdata got=%h exp=%h", nm, bus.rdata, exp_be ? 32'd0 : 32'h1234_5678); end
    total++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin bad++; $display("FAIL %s_done_req_stall got=%b%b exp=00", nm, bus.mem_req, bus.stall); end
    tick();
    total++; if (bus.buserr !== 1'b0 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL %s_idle_buserr_req got=%b%b exp=00", nm, bus.buserr, bus.mem_req); end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_store_wins();
    bus.req_valid = 1'b1;
    bus.st_sel    = 2'b00;
    bus.ld_sel    = 3'd1;
    bus.addr      = 32'h0000_0010;
    bus.wdata     = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    #1;
    total++; if (bus.mem_we !== 1'b1 || bus.mem_byteen !== 4'b1111) begin bad++; $display("FAIL sw_ld_we_be got=%b%b exp=11111", bus.mem_we, bus.mem_byteen); end
    total++; if (bus.mem_addr !== 32'h0000_0010 || bus.mem_wdata !== 32'hDEAD_BEEF)
      begin bad++; $display("FAIL sw_ld_addr_wdata got=%h/%h exp=00000010/deadbeef", bus.mem_addr, bus.mem_wdata); end
    tick();
    bus.mem_ack = 1'b0;
    #1;
    total++; if (bus.rdata_valid !== 1'b0 || bus.rdata !== 32'd0) begin bad++; $display("FAIL sw_ld_done_rv_rdata got=%b/%h exp=0/0", bus.rdata_valid, bus.rdata); end
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset_busy();
    bus.req_valid = 1'b1;
    bus.st_sel    = 2'b00;
    bus.addr      = 32'h0000_0020;
    bus.wdata     = 32'h0102_0304;
    tick();
    idle_inputs();
    #1;
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rstb_busy_req got=%b exp=1", bus.mem_req); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_byteen !== 4'b0000)
      begin bad++; $display("FAIL rstb_async_drop got=%b%b%b exp=000000", bus.mem_req, bus.mem_we, bus.mem_byteen); end
    tick();
    rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    #1;
    total++; if (bus.rdata_valid !== 1'b0 || bus.stall !== 1'b0 || bus.mem_req !== 1'b0)
      begin bad++; $display("FAIL rstb_late_ack got=%b%b%b exp=000", bus.rdata_valid, bus.stall, bus.mem_req); end
    tick();
    total++; if (bus.rdata_valid !== 1'b0 || bus.buserr !== 1'b0) begin bad++; $display("FAIL rstb_after got=%b%b exp=00", bus.rdata_valid, bus.buserr); end
  endtask

  // ---------------------------------------------------------------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_store("sb",  2'b10, 32'h0000_1003, 32'h0000_00AB, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 2);
    test_store("sb0", 2'b10, 32'h0000_1004, 32'h1234_56CD, 32'h0000_1004, 4'b0001, 32'hCDCD_CDCD, 1);
    test_store("sh",  2'b01, 32'h0000_3002, 32'hAAAA_5A5A, 32'h0000_3000, 4'b1100, 32'h5A5A_5A5A, 1);
    test_store("shl", 2'b01, 32'h0000_3000, 32'h0000_BEEF, 32'h0000_3000, 4'b0011, 32'hBEEF_BEEF, 1);
    test_store("sw",  2'b00, 32'h0000_4008, 32'hCAFE_F00D, 32'h0000_4008, 4'b1111, 32'hCAFE_F00D, 3);
    test_load("lh",  3'd2, 32'h0000_2002, 32'h80FF_1234, 32'hFFFF_80FF);
    test_load("lhu", 3'd3, 32'h0000_2002, 32'h80FF_1234, 32'h0000_80FF);
    test_load("lhlo",3'd2, 32'h0000_2000, 32'h80FF_1234, 32'h0000_1234);
    test_load("lb",  3'd4, 32'h0000_2003, 32'h80FF_1234, 32'hFFFF_FF80);
    test_load("lbu", 3'd5, 32'h0000_2003, 32'h80FF_1234, 32'h0000_0080);
    test_load("lb1", 3'd4, 32'h0000_2001, 32'h80FF_1234, 32'h0000_0012);
    test_load("lw",  3'd1, 32'h0000_2004, 32'h80FF_1234, 32'h80FF_1234);
    test_misaligned();
    test_timeout("to", 0);
    test_timeout("ack4", 4);
    test_store_wins();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: max cycles waiting for mem_ack before bus error; legal range 1..255.
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid  in  1  M-stage instruction present.
REQ-005 SHALL have port st_sel  in  2  00 sw, 01 sh, 10 sb, 11 no store.
REQ-006 SHALL have port ld_sel  in  3  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu; 6-7 treated as none.
REQ-007 SHALL have ports addr  in  32  byte address; wdata  in  32  store data, right-aligned.
REQ-008 SHALL have ports mem_req, mem_we  out  1 each; mem_addr  out  32 (bits[1:0]=0); mem_byteen  out  4; mem_wdata  out  32.
REQ-009 SHALL have ports mem_ack  in  1; mem_rdata  in  32.
REQ-010 SHALL have ports stall  out  1; rdata  out  32 (extended load data); rdata_valid  out  1.
REQ-011 SHALL have ports adel, ades, buserr  out  1 each.

Function
REQ-012 SHALL implement FSM IDLE, BUSY, DONE.
REQ-013 In IDLE, an op is present when req_valid=1 and (st_sel!=11 or ld_sel in 1..5); if both, store wins and the load is ignored.
REQ-014 Misalignment: sw/lw with addr[1:0]!=0, sh/lh/lhu with addr[0]=1; sb/lb/lbu never misaligned.
REQ-015 Misaligned op in IDLE: ades (store) or adel (load) SHALL be 1 combinationally that cycle, stall=0, no memory request, FSM stays IDLE.
REQ-016 Aligned op in IDLE: stall=1 combinationally; latch op, addr, wdata; next state BUSY.
REQ-017 In BUSY: mem_req=1, mem_we=1 for stores, mem_addr={addr[31:2],2'b00}, outputs driven from registers, stall=1.
REQ-018 Byte enables: sw 1111; sh 0011 (addr[1]=0) / 1100 (addr[1]=1); sb one-hot 0001/0010/0100/1000 by addr[1:0]; loads 1111.
REQ-019 mem_wdata: sw wdata; sh {2{wdata[15:0]}}; sb {4{wdata[7:0]}}.
REQ-020 BUSY with mem_ack=1: capture mem_rdata, next state DONE.
REQ-021 Wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; when it reaches MAX_WAIT without ack, next state DONE with buserr flagged; ack in the same cycle wins (no buserr).
REQ-022 DONE lasts exactly one cycle: stall=0, mem_req=0, rdata_valid=1 for loads, buserr=1 if timed out; inputs ignored; next state IDLE.
REQ-023 rdata in DONE: lw word; lh/lhu halfword selected by addr[1], sign-/zero-extended; lb/lbu byte selected by addr[1:0], sign-/zero-extended; 0 on buserr or store.
REQ-024 Latency: aligned op in cycle 0, mem_req from cycle 1, ack in cycle k gives DONE in k+1; minimum total stall 2 cycles.
REQ-025 adel/ades/buserr/rdata_valid SHALL be single-cycle pulses; never asserted in BUSY.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, counter 0, captured data 0, and mem_req, mem_we, mem_byteen, rdata_valid, buserr to 0, regardless of clk.
REQ-027 Reset during BUSY SHALL drop mem_req without waiting for mem_ack; a late ack in IDLE is ignored.
REQ-028 Outputs SHALL be valid from the first rising clk edge after rst_n deasserts.

Verification
REQ-029 sb, addr=0x1003, wdata=0xAB, ack on cycle 2 -> mem_addr=0x1000, byteen=1000, mem_wdata=0xABABABAB, stall cycles 0-2, DONE cycle 3.
REQ-030 lh, addr=0x2002, mem_rdata=0x80FF1234, ack immediate -> rdata=0xFFFF80FF, rdata_valid one cycle; lhu same -> 0x000080FF.
REQ-031 lw, addr=0x0001 -> adel=1 same cycle, stall=0, mem_req never asserted; sh addr=0x0003 -> ades=1.
REQ-032 lw, MAX_WAIT=4, no ack -> mem_req 4 cycles, then buserr=1 and rdata=0 for one cycle, then IDLE; rerun with ack on the 4th cycle -> no buserr.
REQ-033 st_sel=00 and ld_sel=1 together, addr=0x10 -> store only: mem_we=1, byteen=1111, rdata_valid=0.
REQ-034 rst_n low mid-BUSY -> mem_req=0 asynchronously; ack after release -> no DONE, no rdata_valid.
